// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master memory arbiter: FSM states, the registered
// downstream request record and the grant identifier used by round-robin mode.
package mem_arbiter_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int BE_WIDTH   = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    typedef struct packed {
        logic                  read;
        logic                  write;
        logic [BE_WIDTH-1:0]   be;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } arb_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, the data port and the downstream memory port.
// slave = arbiter view; master = view of the core plus memory around it.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_address;
    logic                  i_resp;
    logic [DATA_WIDTH-1:0] i_rdata;

    logic                  d_read;
    logic                  d_write;
    logic [BE_WIDTH-1:0]   d_byte_enable;
    logic [ADDR_WIDTH-1:0] d_address;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_resp;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  mem_read;
    logic                  mem_write;
    logic [BE_WIDTH-1:0]   mem_byte_enable;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_resp;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  i_read, i_address,
        output i_resp, i_rdata,
        input  d_read, d_write, d_byte_enable, d_address, d_wdata,
        output d_resp, d_rdata,
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_resp, mem_rdata
    );

    modport master (
        output i_read, i_address,
        input  i_resp, i_rdata,
        output d_read, d_write, d_byte_enable, d_address, d_wdata,
        input  d_resp, d_rdata,
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_resp, mem_rdata
    );

endinterface

// File: rtl/mem_arbiter_req_reg.sv
// arb_req_reg stage: holds the downstream request for the granted master,
// loaded on grant and cleared when the memory responds.
module mem_arbiter_req_reg
    import mem_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load_i,
    input  logic     clear_i,
    input  arb_req_t req_i,
    output arb_req_t req_o
);

    arb_req_t req_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= '0;
        end else if (load_i) begin
            req_q <= req_i;
        end else if (clear_i) begin
            req_q <= '0;
        end
    end

    assign req_o = req_q;

endmodule

// File: rtl/mem_arbiter.sv
// Merges the fetch and data ports onto one memory port, one request in flight.
// Define MEM_ARB_RR_EN to alternate the winner on simultaneous requests.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  arb_io
);

    arb_state_t state_q;
    arb_req_t   req_d;
    arb_req_t   req_q;
    logic       i_req;
    logic       d_req;
    logic       grant_d;
    logic       grant_valid;
    logic       mem_done;
    logic       i_fwd;
    logic       d_fwd;

    assign i_req       = arb_io.i_read;
    assign d_req       = arb_io.d_read | arb_io.d_write;
    assign grant_valid = (state_q == IDLE) && (i_req || d_req);
    assign mem_done    = (state_q != IDLE) && arb_io.mem_resp;

`ifdef MEM_ARB_RR_EN
    grant_t last_grant_q;

    // Only collisions consult and update the history; lone requests never move it.
    assign grant_d = d_req && (!i_req || (last_grant_q == GRANT_I));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= GRANT_I;
        end else if ((state_q == IDLE) && i_req && d_req) begin
            last_grant_q <= grant_d ? GRANT_D : GRANT_I;
        end
    end
`else
    assign grant_d = d_req;
`endif

    always_comb begin
        req_d = '0;
        if (grant_d) begin
            // A simultaneous read+write is performed as the write.
            req_d.read  = arb_io.d_read & ~arb_io.d_write;
            req_d.write = arb_io.d_write;
            req_d.be    = arb_io.d_byte_enable;
            req_d.addr  = arb_io.d_address;
            req_d.wdata = arb_io.d_wdata;
        end else begin
            req_d.read  = 1'b1;
            req_d.be    = '1;
            req_d.addr  = arb_io.i_address;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        state_q <= grant_d ? SERVE_D : SERVE_I;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (arb_io.mem_resp) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mem_arbiter_req_reg u_req_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (grant_valid),
        .clear_i (mem_done),
        .req_i   (req_d),
        .req_o   (req_q)
    );

    assign arb_io.mem_read        = req_q.read;
    assign arb_io.mem_write       = req_q.write;
    assign arb_io.mem_byte_enable = req_q.be;
    assign arb_io.mem_address     = req_q.addr;
    assign arb_io.mem_wdata       = req_q.wdata;

    // A master that withdrew its request mid-flight has its response swallowed.
    assign i_fwd = (state_q == SERVE_I) && arb_io.mem_resp && i_req;
    assign d_fwd = (state_q == SERVE_D) && arb_io.mem_resp && d_req;

    assign arb_io.i_resp  = i_fwd;
    assign arb_io.i_rdata = i_fwd ? arb_io.mem_rdata : '0;
    assign arb_io.d_resp  = d_fwd;
    assign arb_io.d_rdata = d_fwd ? arb_io.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single transactions plus
// hand-written collision, flush, idle-response and mid-flight reset sequences.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk    (clk),
        .rst    (rst),
        .arb_io (bus)
    );

    typedef struct {
        logic        i_read;
        logic [31:0] i_addr;
        logic        d_read;
        logic        d_write;
        logic [3:0]  be;
        logic [31:0] d_addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
        logic        e_read;
        logic        e_write;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_iresp;
        logic        e_dresp;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic check_mem(input string nm, input logic rd, input logic wr,
                             input logic [3:0] be, input logic [31:0] addr,
                             input logic [31:0] wdata);
        chk({nm, ".mem_read"},        {31'd0, bus.mem_read},        {31'd0, rd});
        chk({nm, ".mem_write"},       {31'd0, bus.mem_write},       {31'd0, wr});
        chk({nm, ".mem_byte_enable"}, {28'd0, bus.mem_byte_enable}, {28'd0, be});
        chk({nm, ".mem_address"},     bus.mem_address,              addr);
        chk({nm, ".mem_wdata"},       bus.mem_wdata,                wdata);
    endtask

    task automatic drop_all();
        bus.i_read        = 1'b0;
        bus.i_address     = '0;
        bus.d_read        = 1'b0;
        bus.d_write       = 1'b0;
        bus.d_byte_enable = '0;
        bus.d_address     = '0;
        bus.d_wdata       = '0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        bus.i_read        = v.i_read;
        bus.i_address     = v.i_addr;
        bus.d_read        = v.d_read;
        bus.d_write       = v.d_write;
        bus.d_byte_enable = v.be;
        bus.d_address     = v.d_addr;
        bus.d_wdata       = v.wdata;
        @(negedge clk);
        check_mem($sformatf("v%0d.grant", idx), v.e_read, v.e_write, v.e_be, v.e_addr, v.e_wdata);
        for (int k = 0; k < v.waits; k++) begin
            @(negedge clk);
            check_mem($sformatf("v%0d.hold%0d", idx, k), v.e_read, v.e_write, v.e_be, v.e_addr, v.e_wdata);
        end
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = v.rdata;
        #1;
        chk($sformatf("v%0d.i_resp", idx), {31'd0, bus.i_resp}, {31'd0, v.e_iresp});
        chk($sformatf("v%0d.d_resp", idx), {31'd0, bus.d_resp}, {31'd0, v.e_dresp});
        if (v.e_iresp) chk($sformatf("v%0d.i_rdata", idx), bus.i_rdata, v.rdata);
        if (v.e_dresp && v.e_read) chk($sformatf("v%0d.d_rdata", idx), bus.d_rdata, v.rdata);
        @(negedge clk);
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        drop_all();
        #1;
        chk($sformatf("v%0d.idle_read", idx),  {31'd0, bus.mem_read},  32'd0);
        chk($sformatf("v%0d.idle_write", idx), {31'd0, bus.mem_write}, 32'd0);
        $display("txn %0d: addr=%h rd=%0b wr=%0b be=%h waits=%0d", idx, v.e_addr,
                 v.e_read, v.e_write, v.e_be, v.waits);
    endtask

    // Fetch 0x60 and load 0x200 requested in the same cycle.
    task automatic collide(input string nm, input logic d_first);
        @(negedge clk);
        bus.i_read        = 1'b1;
        bus.i_address     = 32'h60;
        bus.d_read        = 1'b1;
        bus.d_address     = 32'h200;
        bus.d_byte_enable = 4'hF;
        @(negedge clk);
        check_mem({nm, ".first"}, 1'b1, 1'b0, 4'hF, d_first ? 32'h200 : 32'h60, 32'h0);
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = d_first ? 32'h0000_00D0 : 32'h0000_0010;
        #1;
        chk({nm, ".first_d_resp"}, {31'd0, bus.d_resp}, {31'd0, d_first});
        chk({nm, ".first_i_resp"}, {31'd0, bus.i_resp}, {31'd0, ~d_first});
        if (d_first) chk({nm, ".first_d_rdata"}, bus.d_rdata, 32'h0000_00D0);
        else         chk({nm, ".first_i_rdata"}, bus.i_rdata, 32'h0000_0010);
        @(negedge clk);
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        if (d_first) bus.d_read = 1'b0;
        else         bus.i_read = 1'b0;
        #1;
        chk({nm, ".turnaround_idle"}, {31'd0, bus.mem_read}, 32'd0);
        @(negedge clk);
        check_mem({nm, ".second"}, 1'b1, 1'b0, 4'hF, d_first ? 32'h60 : 32'h200, 32'h0);
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'h0000_0777;
        #1;
        chk({nm, ".second_i_resp"}, {31'd0, bus.i_resp}, {31'd0, d_first});
        chk({nm, ".second_d_resp"}, {31'd0, bus.d_resp}, {31'd0, ~d_first});
        @(negedge clk);
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        drop_all();
        $display("txn %s: collision served %s first", nm, d_first ? "D" : "I");
    endtask

    initial begin
        drop_all();
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;

        //            i_rd i_addr      d_rd d_wr be     d_addr       wdata         w  rdata         e_rd e_wr e_be   e_addr       e_wdata       ir   dr
        vecs[0] = '{1'b1, 32'h60,     1'b0, 1'b0, 4'h0, 32'h0,       32'h0,        2, 32'h0000_0013, 1'b1, 1'b0, 4'hF, 32'h60,      32'h0,        1'b1, 1'b0};
        vecs[1] = '{1'b1, 32'h64,     1'b0, 1'b0, 4'h5, 32'h999,     32'h1234_5678,0, 32'h0000_006F, 1'b1, 1'b0, 4'hF, 32'h64,      32'h0,        1'b1, 1'b0};
        vecs[2] = '{1'b0, 32'h0,      1'b0, 1'b1, 4'h3, 32'h100,     32'hDEAD_BEEF,5, 32'h0,         1'b0, 1'b1, 4'h3, 32'h100,     32'hDEAD_BEEF,1'b0, 1'b1};
        vecs[3] = '{1'b0, 32'h0,      1'b1, 1'b1, 4'hF, 32'h104,     32'hCAFE_F00D,1, 32'h0,         1'b0, 1'b1, 4'hF, 32'h104,     32'hCAFE_F00D,1'b0, 1'b1};
        vecs[4] = '{1'b0, 32'h0,      1'b1, 1'b0, 4'h0, 32'h208,     32'h0,        0, 32'h1122_3344, 1'b1, 1'b0, 4'h0, 32'h208,     32'h0,        1'b0, 1'b1};
        vecs[5] = '{1'b0, 32'h0,      1'b0, 1'b1, 4'hC, 32'h10C,     32'h0000_A5A5,3, 32'h0,         1'b0, 1'b1, 4'hC, 32'h10C,     32'h0000_A5A5,1'b0, 1'b1};

        // Reset state.
        #2;
        check_mem("reset", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("reset.i_resp", {31'd0, bus.i_resp}, 32'd0);
        chk("reset.d_resp", {31'd0, bus.d_resp}, 32'd0);
        chk("reset.i_rdata", bus.i_rdata, 32'd0);
        chk("reset.d_rdata", bus.d_rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 6; n++) begin
            run_vec(n, vecs[n]);
        end

        collide("coll1", 1'b1);
`ifdef MEM_ARB_RR_EN
        collide("coll2", 1'b0);
`else
        collide("coll2", 1'b1);
`endif

        // Fetch withdrawn after grant: downstream completes, response swallowed,
        // and a load raised meanwhile is served next.
        @(negedge clk);
        bus.i_read    = 1'b1;
        bus.i_address = 32'h60;
        @(negedge clk);
        check_mem("flush.grant", 1'b1, 1'b0, 4'hF, 32'h60, 32'h0);
        bus.i_read        = 1'b0;
        bus.d_read        = 1'b1;
        bus.d_address     = 32'h300;
        bus.d_byte_enable = 4'hF;
        @(negedge clk);
        check_mem("flush.hold", 1'b1, 1'b0, 4'hF, 32'h60, 32'h0);
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'h0000_BAD0;
        #1;
        chk("flush.i_resp", {31'd0, bus.i_resp}, 32'd0);
        chk("flush.d_resp", {31'd0, bus.d_resp}, 32'd0);
        @(negedge clk);
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        #1;
        chk("flush.idle", {31'd0, bus.mem_read}, 32'd0);
        @(negedge clk);
        check_mem("flush.next", 1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'h5555_0300;
        #1;
        chk("flush.next_d_resp", {31'd0, bus.d_resp}, 32'd1);
        chk("flush.next_d_rdata", bus.d_rdata, 32'h5555_0300);
        chk("flush.next_i_resp", {31'd0, bus.i_resp}, 32'd0);
        @(negedge clk);
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        drop_all();
        $display("txn flush: swallowed fetch 0x60, served load 0x300");

        // Stray memory response while idle.
        @(negedge clk);
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("idle_resp.i_resp", {31'd0, bus.i_resp}, 32'd0);
        chk("idle_resp.d_resp", {31'd0, bus.d_resp}, 32'd0);
        @(negedge clk);
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        check_mem("idle_resp.after", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        $display("txn idle_resp: ignored");

        // Asynchronous reset in the middle of a data transaction.
        @(negedge clk);
        bus.d_read        = 1'b1;
        bus.d_address     = 32'h400;
        bus.d_byte_enable = 4'hF;
        @(negedge clk);
        check_mem("rst_mid.grant", 1'b1, 1'b0, 4'hF, 32'h400, 32'h0);
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'h0000_4444;
        #1;
        chk("rst_mid.d_resp_before", {31'd0, bus.d_resp}, 32'd1);
        rst = 1'b1;
        #1;
        check_mem("rst_mid.after", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("rst_mid.d_resp", {31'd0, bus.d_resp}, 32'd0);
        chk("rst_mid.d_rdata", bus.d_rdata, 32'd0);
        @(negedge clk);
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        drop_all();
        rst = 1'b0;
        bus.i_read    = 1'b1;
        bus.i_address = 32'h80;
        @(negedge clk);
        check_mem("rst_mid.fresh", 1'b1, 1'b0, 4'hF, 32'h80, 32'h0);
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'h0000_0080;
        #1;
        chk("rst_mid.fresh_i_resp", {31'd0, bus.i_resp}, 32'd1);
        chk("rst_mid.fresh_i_rdata", bus.i_rdata, 32'h0000_0080);
        @(negedge clk);
        bus.mem_resp  = 1'b0;
        drop_all();
        $display("txn rst_mid: reset abandoned load 0x400, fetch 0x80 served");

        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
